obi_axil_master: RTL and testbench

- Bridges the cv32e40p OBI data/instruction port (req/gnt/rvalid) to an AXI4-Lite master interface.
- Drives AXI4-Lite slaves such as the on-chip RAM and the peripherals on the SoC interconnect.
- Supports one outstanding transaction: accept an OBI request, issue the AXI read or write, collect the response, return the OBI response.

---
 rtl/obi_axil_master.sv | 166 ++++++++++++++++
 tb/tb_obi_axil_master.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_axil_master.sv
// obi_axil_master: bridges a cv32e40p OBI port (req/gnt/rvalid) to an
// AXI4-Lite master with a single outstanding transaction.
// Optional build macro OBI_AXIL_RESP_EN adds bresp/rresp inputs and maps
// resp[1] (SLVERR/DECERR) onto obi_err.
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; a valid, once raised, is held together with its
// address/data/strobe until that edge, and only then dropped.
module obi_axil_master #(
    parameter bit ALIGN_ADDR   = 1'b1,
    parameter bit OBI_WRITE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef OBI_AXIL_RESP_EN
    input  logic [1:0]  bresp,
    input  logic [1:0]  rresp,
`endif
    input  logic        obi_req,
    output logic        obi_gnt,
    input  logic [31:0] obi_addr,
    input  logic        obi_we,
    input  logic [3:0]  obi_be,
    input  logic [31:0] obi_wdata,
    output logic        obi_rvalid,
    output logic [31:0] obi_rdata,
    output logic        obi_err,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] addr_al;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        r_hs;
`ifdef OBI_AXIL_RESP_EN
    logic        b_hs;
    logic        unused_resp_lsb;
`endif

    assign addr_al    = ALIGN_ADDR ? {obi_addr[31:2], 2'b00} : obi_addr;
    assign obi_gnt    = obi_req && (state == IDLE);
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;
    assign bready     = (state == WR_RESP);
    assign rready     = (state == RD_RESP);
    assign obi_rvalid = (state == DONE);
    assign dbg_state  = state;
`ifdef OBI_AXIL_RESP_EN
    assign b_hs            = bvalid && bready;
    // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    assign unused_resp_lsb = bresp[0] ^ rresp[0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a write waits until both aw and w have completed,
    // which is when each valid has dropped or is completing this cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (obi_gnt) begin
                    if (!obi_we)          state_nx = RD_REQ;
                    else if (OBI_WRITE_EN) state_nx = WR_REQ;
                    else                  state_nx = DONE;
                end
            end
            WR_REQ:  if ((!awvalid || awready) && (!wvalid || wready)) state_nx = WR_RESP;
            WR_RESP: if (bvalid)  state_nx = DONE;
            RD_REQ:  if (arready) state_nx = RD_RESP;
            RD_RESP: if (rvalid)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // AXI request channels: raised on grant, each dropped after its own handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            arvalid <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            araddr  <= '0;
        end else begin
            if (obi_gnt && obi_we && OBI_WRITE_EN) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= addr_al;
                wdata   <= obi_wdata;
                wstrb   <= obi_be;
            end else begin
                if (aw_hs) awvalid <= 1'b0;
                if (w_hs)  wvalid  <= 1'b0;
            end
            if (obi_gnt && !obi_we) begin
                arvalid <= 1'b1;
                araddr  <= addr_al;
            end else if (ar_hs) begin
                arvalid <= 1'b0;
            end
        end
    end

    // OBI response data: cleared on grant, filled on the AXI response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obi_rdata <= '0;
            obi_err   <= 1'b0;
        end else begin
            if (obi_gnt) begin
                obi_rdata <= '0;
                // A write on a read-only port is refused without AXI traffic.
                obi_err   <= obi_we && !OBI_WRITE_EN;
            end else if (r_hs) begin
                obi_rdata <= rdata;
`ifdef OBI_AXIL_RESP_EN
                obi_err   <= rresp[1];
`endif
            end
`ifdef OBI_AXIL_RESP_EN
            else if (b_hs) begin
                obi_err <= bresp[1];
            end
`endif
        end
    end

endmodule

// File: tb/tb_obi_axil_master.sv
// tb_obi_axil_master: self-checking bench for obi_axil_master.
// dut uses the default parameters; dut_ro (ALIGN_ADDR=0, OBI_WRITE_EN=0)
// shares the same OBI stimulus and AXI slave inputs and is observed only.
module tb_obi_axil_master;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- OBI stimulus ----------------
    logic        obi_req, obi_we;
    logic [31:0] obi_addr, obi_wdata;
    logic [3:0]  obi_be;

    // ---------------- dut outputs ----------------
    logic        obi_gnt, obi_rvalid, obi_err;
    logic [31:0] obi_rdata;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [2:0]  dbg_state;

    // ---------------- dut_ro outputs ----------------
    logic        obi_gnt2, obi_rvalid2, obi_err2;
    logic [31:0] obi_rdata2;
    logic [31:0] awaddr2, wdata2, araddr2;
    logic [3:0]  wstrb2;
    logic        awvalid2, wvalid2, bready2, arvalid2, rready2;
    logic [2:0]  dbg_state2;

    // ---------------- AXI slave model signals ----------------
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] rdata;
    logic [1:0]  bresp_tb = 2'b00;
    logic [1:0]  rresp_tb = 2'b00;
    int          aw_wait = 0;
    int          w_wait  = 0;
    logic        b_hold  = 1'b0;

    int          aw_cnt, w_cnt;
    logic        aw_have, w_have, bvalid_q;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    logic [31:0] mem [0:255];
    logic        mem_inited = 1'b0;

    assign awready = (aw_cnt >= aw_wait);
    assign wready  = (w_cnt >= w_wait);
    assign arready = 1'b1;
    assign bvalid  = bvalid_q && !b_hold;

    obi_axil_master dut (
        .clk(clk), .rst_n(rst_n),
`ifdef OBI_AXIL_RESP_EN
        .bresp(bresp_tb), .rresp(rresp_tb),
`endif
        .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we),
        .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_rvalid(obi_rvalid),
        .obi_rdata(obi_rdata), .obi_err(obi_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .dbg_state(dbg_state)
    );

    obi_axil_master #(.ALIGN_ADDR(1'b0), .OBI_WRITE_EN(1'b0)) dut_ro (
        .clk(clk), .rst_n(rst_n),
`ifdef OBI_AXIL_RESP_EN
        .bresp(bresp_tb), .rresp(rresp_tb),
`endif
        .obi_req(obi_req), .obi_gnt(obi_gnt2), .obi_addr(obi_addr), .obi_we(obi_we),
        .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_rvalid(obi_rvalid2),
        .obi_rdata(obi_rdata2), .obi_err(obi_err2),
        .awaddr(awaddr2), .awvalid(awvalid2), .awready(awready),
        .wdata(wdata2), .wstrb(wstrb2), .wvalid(wvalid2), .wready(wready),
        .bvalid(bvalid), .bready(bready2),
        .araddr(araddr2), .arvalid(arvalid2), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready2),
        .dbg_state(dbg_state2)
    );

    // AXI4-Lite slave with a 256-word RAM: awready/wready can be stalled for
    // aw_wait/w_wait cycles, response one cycle after the handshake.
    // The RAM is cleared on the first reset only.
    always @(posedge clk or negedge rst_n) begin : slave
        logic        aw_ok, w_ok;
        logic [31:0] a_t, d_t, m;
        logic [3:0]  s_t;
        if (!rst_n) begin
            aw_cnt   <= 0;
            w_cnt    <= 0;
            aw_have  <= 1'b0;
            w_have   <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            aw_a     <= '0;
            w_d      <= '0;
            w_s      <= '0;
            if (!mem_inited) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
                mem_inited <= 1'b1;
            end
        end else begin
            aw_ok = aw_have || (awvalid && awready);
            w_ok  = w_have || (wvalid && wready);
            a_t   = aw_have ? aw_a : awaddr;
            d_t   = w_have ? w_d : wdata;
            s_t   = w_have ? w_s : wstrb;
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (wvalid && !wready)   w_cnt  <= w_cnt + 1;
            if (awvalid && awready) begin
                aw_cnt <= 0; aw_have <= 1'b1; aw_a <= awaddr;
            end
            if (wvalid && wready) begin
                w_cnt <= 0; w_have <= 1'b1; w_d <= wdata; w_s <= wstrb;
            end
            if (bvalid && bready) bvalid_q <= 1'b0;
            if (aw_ok && w_ok) begin
                m = mem[a_t[9:2]];
                for (int b = 0; b < 4; b++) if (s_t[b]) m[8*b +: 8] = d_t[8*b +: 8];
                mem[a_t[9:2]] <= m;
                aw_have  <= 1'b0;
                w_have   <= 1'b0;
                bvalid_q <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[9:2]];
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];   // {obi_err, obi_rdata}
    int n_checks = 0;
    int n_pass   = 0;

    // observations collected by obi_txn
    int          aw_cyc, w_cyc, ar_cyc, b_cyc;
    logic [31:0] ar_a, ar_a2;
    logic        aw2_seen, rv2_seen, err2;
    logic [31:0] rdata2;

    // Drives one OBI transaction, pushes its expected response at grant and
    // pops/compares it when obi_rvalid appears. lat = cycles grant->rvalid.
    task automatic obi_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [32:0] exp, output int lat);
        int          n;
        logic [32:0] e;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0; b_cyc = 0;
        ar_a = '0; ar_a2 = '0; aw2_seen = 1'b0; rv2_seen = 1'b0; err2 = 1'b0; rdata2 = '0;
        lat = -1;
        @(negedge clk);
        obi_req = 1'b1; obi_we = we; obi_addr = addr; obi_be = be; obi_wdata = wd;
        #1;
        n = 0;
        while (!obi_gnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        n_checks++;
        if (!obi_gnt) begin
            $display("FAIL gnt_timeout addr=%h: gnt=%b required 1", addr, obi_gnt);
            obi_req = 1'b0;
            return;
        end
        n_pass++;
        exp_q.push_back(exp);
        @(negedge clk);
        obi_req = 1'b0;
        lat = 1;
        while (lat < 40) begin
            if (awvalid) aw_cyc++;
            if (wvalid)  w_cyc++;
            if (bready)  b_cyc++;
            if (arvalid) begin ar_cyc++; ar_a = araddr; end
            if (arvalid2) ar_a2 = araddr2;
            if (awvalid2) aw2_seen = 1'b1;
            if (obi_rvalid2) begin rv2_seen = 1'b1; err2 = obi_err2; rdata2 = obi_rdata2; end
            if (obi_rvalid) break;
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (!obi_rvalid) begin
            $display("FAIL rvalid_timeout addr=%h: obi_rvalid=%b required 1", addr, obi_rvalid);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        n_checks++;
        if ({obi_err, obi_rdata} !== e)
            $display("FAIL resp addr=%h: got err=%b rdata=%h, required err=%b rdata=%h",
                     addr, obi_err, obi_rdata, e[32], e[31:0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obi_rvalid !== 1'b0) $display("FAIL rvalid_pulse: obi_rvalid=%b required 0", obi_rvalid);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({obi_gnt, obi_rvalid, obi_err, awvalid, wvalid, bready, arvalid, rready} !== 8'b0)
            $display("FAIL reset_ctrl: gnt/rv/err/awv/wv/bry/arv/rry=%b required 00000000",
                     {obi_gnt, obi_rvalid, obi_err, awvalid, wvalid, bready, arvalid, rready});
        else n_pass++;
        n_checks++;
        if ({obi_rdata, awaddr, araddr, wdata, wstrb} !== 132'h0)
            $display("FAIL reset_data: rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h required all 0",
                     obi_rdata, awaddr, araddr, wdata, wstrb);
        else n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state: state=%0d required 0", dbg_state);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_rw;
        int lat;
        obi_txn(1'b1, 32'h10, 4'hf, 32'hDEADBEEF, 33'h0, lat);
        n_checks++;
        if (lat !== 3 || aw_cyc !== 1 || w_cyc !== 1)
            $display("FAIL write_zero_wait: lat=%0d aw=%0d w=%0d required 3/1/1", lat, aw_cyc, w_cyc);
        else n_pass++;
        obi_txn(1'b0, 32'h10, 4'hf, 32'h0, {1'b0, 32'hDEADBEEF}, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL read_latency: lat=%0d required 3", lat);
        else n_pass++;
        n_checks++;
        if (ar_a !== 32'h10 || ar_cyc !== 1)
            $display("FAIL read_araddr: araddr=%h cycles=%0d required 00000010/1", ar_a, ar_cyc);
        else n_pass++;
    endtask

    task automatic test_write_stall;
        int lat;
        aw_wait = 3;
        obi_txn(1'b1, 32'h24, 4'b0101, 32'h11223344, 33'h0, lat);
        aw_wait = 0;
        n_checks++;
        if (w_cyc !== 1 || aw_cyc !== 4 || b_cyc !== 1 || lat !== 6)
            $display("FAIL write_stall: w=%0d aw=%0d b=%0d lat=%0d required 1/4/1/6",
                     w_cyc, aw_cyc, b_cyc, lat);
        else n_pass++;
        obi_txn(1'b0, 32'h24, 4'hf, 32'h0, {1'b0, 32'h00220044}, lat);
    endtask

    task automatic test_align;
        int lat;
        obi_txn(1'b0, 32'h1003, 4'hf, 32'h0, 33'h0, lat);
        n_checks++;
        if (ar_a !== 32'h1000) $display("FAIL align_on: araddr=%h required 00001000", ar_a);
        else n_pass++;
        n_checks++;
        if (ar_a2 !== 32'h1003) $display("FAIL align_off: araddr=%h required 00001003", ar_a2);
        else n_pass++;
    endtask

    task automatic test_read_only;
        int lat;
        obi_txn(1'b1, 32'h40, 4'hf, 32'hCAFEF00D, 33'h0, lat);
        n_checks++;
        if (rv2_seen !== 1'b1 || err2 !== 1'b1 || rdata2 !== 32'h0 || aw2_seen !== 1'b0)
            $display("FAIL read_only_write: rvalid=%b err=%b rdata=%h awvalid_seen=%b required 1/1/0/0",
                     rv2_seen, err2, rdata2, aw2_seen);
        else n_pass++;
        obi_txn(1'b0, 32'h40, 4'hf, 32'h0, {1'b0, 32'hCAFEF00D}, lat);
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [31:0] vals [3];
        logic [32:0] e;
        int g = 0, r = 0, last_g = 0, cyc = 0;
        bit adv = 1'b0;
        addrs = '{32'h10, 32'h24, 32'h40};
        vals  = '{32'hDEADBEEF, 32'h00220044, 32'hCAFEF00D};
        @(negedge clk);
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = addrs[0]; obi_be = 4'hf;
        while (r < 3 && cyc < 60) begin
            #1;
            if (obi_gnt) begin
                n_checks++;
                if (dbg_state !== 3'd0) $display("FAIL b2b_gnt_state: state=%0d required 0", dbg_state);
                else n_pass++;
                if (g > 0) begin
                    n_checks++;
                    if (cyc - last_g !== 4) $display("FAIL b2b_spacing: %0d cycles required 4", cyc - last_g);
                    else n_pass++;
                end
                if (g < 3) exp_q.push_back({1'b0, vals[g]});
                last_g = cyc;
                g++;
                adv = 1'b1;
            end
            if (obi_rvalid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
                n_checks++;
                if ({obi_err, obi_rdata} !== e)
                    $display("FAIL b2b_resp%0d: got err=%b rdata=%h, required err=%b rdata=%h",
                             r, obi_err, obi_rdata, e[32], e[31:0]);
                else n_pass++;
                r++;
            end
            @(negedge clk);
            cyc++;
            if (adv) begin
                if (g < 3) obi_addr = addrs[g];
                else obi_req = 1'b0;
                adv = 1'b0;
            end
        end
        obi_req = 1'b0;
        n_checks++;
        if (g !== 3 || r !== 3) $display("FAIL b2b_count: grants=%0d rvalids=%0d required 3/3", g, r);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int n, lat;
        logic rv_seen = 1'b0;
        b_hold = 1'b1;
        @(negedge clk);
        obi_req = 1'b1; obi_we = 1'b1; obi_addr = 32'h30; obi_be = 4'hf; obi_wdata = 32'h55;
        #1;
        n = 0;
        while (!obi_gnt && n < 20) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        obi_req = 1'b0; obi_we = 1'b0;
        n = 0;
        while (dbg_state !== 3'd2 && n < 20) begin @(negedge clk); n++; end
        n_checks++;
        if (dbg_state !== 3'd2) $display("FAIL mid_reach_wr_resp: state=%0d required 2", dbg_state);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, obi_rvalid, obi_gnt} !== 7'b0 || dbg_state !== 3'd0)
            $display("FAIL mid_reset_clear: awv/wv/bry/arv/rry/rv/gnt=%b state=%0d required 0000000/0",
                     {awvalid, wvalid, bready, arvalid, rready, obi_rvalid, obi_gnt}, dbg_state);
        else n_pass++;
        repeat (2) begin
            @(negedge clk);
            if (obi_rvalid) rv_seen = 1'b1;
        end
        rst_n = 1'b1;
        b_hold = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (obi_rvalid) rv_seen = 1'b1;
        end
        n_checks++;
        if (rv_seen !== 1'b0) $display("FAIL mid_no_rvalid: rvalid_seen=%b required 0", rv_seen);
        else n_pass++;
        obi_txn(1'b0, 32'h10, 4'hf, 32'h0, {1'b0, 32'hDEADBEEF}, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL mid_next_read: lat=%0d required 3", lat);
        else n_pass++;
    endtask

`ifdef OBI_AXIL_RESP_EN
    task automatic test_resp;
        int lat;
        obi_txn(1'b1, 32'h50, 4'hf, 32'hAAAA5555, 33'h0, lat);
        rresp_tb = 2'b10;
        obi_txn(1'b0, 32'h50, 4'hf, 32'h0, {1'b1, 32'hAAAA5555}, lat);
        rresp_tb = 2'b00;
        bresp_tb = 2'b11;
        obi_txn(1'b1, 32'h54, 4'hf, 32'h1, {1'b1, 32'h0}, lat);
        bresp_tb = 2'b00;
        obi_txn(1'b0, 32'h50, 4'hf, 32'h0, {1'b0, 32'hAAAA5555}, lat);
    endtask
`endif

    initial begin
        obi_req = 1'b0; obi_we = 1'b0; obi_addr = '0; obi_be = '0; obi_wdata = '0;
        rst_n = 1'b1;
        test_reset;
        test_basic_rw;
        test_write_stall;
        test_align;
        test_read_only;
        test_back_to_back;
        test_reset_mid;
`ifdef OBI_AXIL_RESP_EN
        test_resp;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
